// File: rtl/rs232_rxfifo.sv
// ============================================================================
// rs232_rxfifo
// Receive buffer between the RS-232 receiver and the CPU I/O bus. Each byte
// offered by the receiver is acknowledged with a one-cycle rx_done pulse and
// stored in a 2^DEPTH_LOG2 x 8 FIFO. The head byte, a ready flag, the fill
// count and a sticky overrun flag are presented to the CPU read path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs232_rxfifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_rdy_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_done_o,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic                  clr_ovf_i,
    output logic [7:0]            dout_o,
    output logic                  rdy_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  ovf_o
);

    localparam int                     DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]    CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0]  PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   rx_done_q;
    logic [7:0]             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wp_q, wp_d;
    logic [DEPTH_LOG2-1:0]  rp_q, rp_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   ovf_q, ovf_d;

    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop_ok;
    logic                   push_ok;
    logic                   overrun;

    // A capture happens exactly on the IDLE->ACK transition.
    assign push    = (state_q == S_IDLE) && rx_rdy_i;
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign pop_ok  = pop_i && !empty;
    // A same-cycle pop frees the slot, so a push at full still fits.
    assign push_ok = push && (!full || pop_ok);
    // Flush discards the incoming byte without flagging it as lost.
    assign overrun = push && full && !pop_ok && !flush_i;

    // Capture handshake: acknowledge once, then wait for the receiver to let go.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_rdy_i) begin
                        state_q   <= S_ACK;
                        rx_done_q <= 1'b1;
                    end
                end
                S_ACK:   state_q <= S_WAIT;
                S_WAIT:  if (!rx_rdy_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Pointer, count and overrun next-state; flush overrides push and pop.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush_i) begin
            rp_d    = wp_q;
            count_d = '0;
        end else begin
            if (push_ok) wp_d = wp_q + PTR_ONE;
            if (pop_ok)  rp_d = rp_q + PTR_ONE;
            if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
            else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
        end
        // Set wins over a simultaneous clear.
        if (overrun)        ovf_d = 1'b1;
        else if (clr_ovf_i) ovf_d = 1'b0;
        else                ovf_d = ovf_q;
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage array; contents need no reset since count gates the output.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wp_q] <= rx_data_i;
    end

    assign dout_o    = empty ? 8'h00 : mem_q[rp_q];
    assign rdy_o     = !empty;
    assign count_o   = count_q;
    assign ovf_o     = ovf_q;
    assign rx_done_o = rx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_rs232_rxfifo.sv
// ============================================================================
// tb_rs232_rxfifo
// Directed and randomized stimulus for rs232_rxfifo, checked against a
// queue-based reference model of the receive buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rs232_rxfifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rx_rdy = 1'b0;
    logic [7:0]           rx_data = 8'h00;
    logic                 pop = 1'b0;
    logic                 flush = 1'b0;
    logic                 clr_ovf = 1'b0;
    logic                 rx_done;
    logic [7:0]           dout;
    logic                 rdy;
    logic [DEPTH_LOG2:0]  count;
    logic                 ovf;

    int total = 0;
    int bad   = 0;

    // Reference model: stored bytes oldest-first, plus the sticky flag.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;

    rs232_rxfifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .rx_rdy_i  (rx_rdy),
        .rx_data_i (rx_data),
        .rx_done_o (rx_done),
        .pop_i     (pop),
        .flush_i   (flush),
        .clr_ovf_i (clr_ovf),
        .dout_o    (dout),
        .rdy_o     (rdy),
        .count_o   (count),
        .ovf_o     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (mq.size() != 0) ? mq[0] : 8'h00;
        chk({tag, ".rdy"},   32'(rdy),   32'(mq.size() != 0));
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".dout"},  32'(dout),  32'(head));
        chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    endtask

    // One clock edge of the buffer's rules applied to the model.
    function automatic void model_edge(bit push, logic [7:0] b, bit p, bit f, bit c);
        bit overran;
        overran = 1'b0;
        if (f) begin
            mq.delete();
        end else begin
            if (p && mq.size() > 0) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(b);
                else overran = 1'b1;
            end
        end
        if (overran) m_ovf = 1'b1;
        else if (c)  m_ovf = 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // CPU-side cycle with no receiver activity.
    task automatic bus_cycle(input bit p, input bit f, input bit c);
        pop = p; flush = f; clr_ovf = c;
        step();
        model_edge(1'b0, 8'h00, p, f, c);
        pop = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        check_state("bus");
        chk("bus.rx_done", 32'(rx_done), 32'd0);
    endtask

    // Receiver offers one byte; CPU strobes may coincide with the capture edge.
    task automatic send(input logic [7:0] b, input int hold, input bit p, input bit f, input bit c);
        rx_rdy = 1'b1; rx_data = b;
        pop = p; flush = f; clr_ovf = c;
        step();
        model_edge(1'b1, b, p, f, c);
        pop = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        chk("send.ack", 32'(rx_done), 32'd1);
        check_state("send");
        for (int i = 0; i < hold; i++) begin
            step();
            chk("send.hold", 32'(rx_done), 32'd0);
        end
        rx_rdy = 1'b0;
        rx_data = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("send.wait", 32'(rx_done), 32'd0);
        end
        check_state("send.end");
    endtask

    initial begin
        // Reset with receiver idle.
        repeat (2) step();
        check_state("reset");
        chk("reset.rx_done", 32'(rx_done), 32'd0);
        rst_n = 1'b1;
        step();

        // Single byte then pop back to empty.
        send(8'h41, 0, 1'b0, 1'b0, 1'b0);
        bus_cycle(1'b1, 1'b0, 1'b0);

        // Long-held rx_rdy yields one capture only.
        send(8'h55, 10, 1'b0, 1'b0, 1'b0);
        bus_cycle(1'b1, 1'b0, 1'b0);

        // Fill, overrun, drain, underflow attempt, clear.
        for (int i = 0; i < 16; i++) send(8'(i), 0, 1'b0, 1'b0, 1'b0);
        send(8'h10, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) bus_cycle(1'b1, 1'b0, 1'b0);
        bus_cycle(1'b1, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b0, 1'b1);

        // Push at full with a simultaneous pop.
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 0, 1'b0, 1'b0, 1'b0);
        send(8'hAA, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) bus_cycle(1'b1, 1'b0, 1'b0);
        bus_cycle(1'b1, 1'b0, 1'b0);

        // Interleaved traffic wraps the pointers.
        for (int i = 0; i < 20; i++) begin
            send(8'h60 + 8'(i), 0, 1'b0, 1'b0, 1'b0);
            bus_cycle(1'b1, 1'b0, 1'b0);
        end

        // Flush coinciding with a push; overrun coinciding with clr_ovf.
        for (int i = 0; i < 17; i++) send(8'hC0 + 8'(i), 0, 1'b0, 1'b0, 1'b0);
        send(8'h33, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(8'hD0 + 8'(i), 0, 1'b0, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b0, 1'b1);
        send(8'h99, 0, 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b0, 1'b1, 1'b1);

        // Randomized mix of captures and CPU cycles.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 6)
                send(8'($urandom), int'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 7) == 0);
            else
                bus_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 7) == 0);
        end

        // Reset asserted while in ACK with rx_rdy still held.
        bus_cycle(1'b0, 1'b1, 1'b1);
        rx_rdy = 1'b1; rx_data = 8'h77;
        step();
        model_edge(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("rstmid.ack", 32'(rx_done), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_state("rstmid.inreset");
        chk("rstmid.rx_done", 32'(rx_done), 32'd0);
        #2 rst_n = 1'b1;
        step();
        model_edge(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("rstmid.recap", 32'(rx_done), 32'd1);
        check_state("rstmid.recap");
        rx_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid.wait", 32'(rx_done), 32'd0);
        end
        check_state("rstmid.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
